// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the transmit-FIFO state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    localparam int C_DBIT          = 8;
    localparam int C_FIFO_ADDR_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10
    } tx_fifo_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_fifo_ram.sv
//==============================================================================
// Module      : uart_fifo_ram
// Description : 2**ADDR_W x DBIT storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DBIT   = C_DBIT,
    parameter int ADDR_W = C_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DBIT-1:0]   wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DBIT-1:0]   rd_data_o
);

    // Contents are deliberately not reset; occupancy is tracked by the owner.
    logic [DBIT-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_fifo_ram

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//==============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding a UART transmitter one byte per handshake.
//               Optional macro UART_TX_FIFO_LEVEL_EN adds the level port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT   = C_DBIT,
    parameter int ADDR_W = C_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              tx_start,
    output logic [DBIT-1:0]   din,
    input  logic              tx_done_tick,
    output logic              busy
`ifdef UART_TX_FIFO_LEVEL_EN
   ,output logic [ADDR_W:0]   level
`endif
);

    localparam int              DEPTH        = 2**ADDR_W;
    localparam logic [ADDR_W:0] C_FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overflow_q;
    tx_fifo_state_t    state_q;
    logic [DBIT-1:0]   din_q;
    logic              tx_start_q;
    logic              busy_q;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_accept;
    logic              w_pop;
    logic [DBIT-1:0]   w_rd_data;

    assign w_full      = (count_q == C_FULL_COUNT);
    assign w_empty     = (count_q == '0);
    // Fullness is judged before any same-cycle pop: a pop never makes room.
    assign w_wr_accept = wr_en && !w_full;
    assign w_pop       = (state_q == IDLE) && !w_empty;

    uart_fifo_ram #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (w_wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (w_wr_accept && !w_pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (!w_wr_accept && w_pop) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= wr_en && w_full;
        end
    end

    // Transmit handshake: load a byte, pulse start once, hold until done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            din_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pop) begin
                        din_q      <= w_rd_data;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    tx_start_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign din      = din_q;
    assign busy     = busy_q;

`ifdef UART_TX_FIFO_LEVEL_EN
    assign level = count_q;
`endif

endmodule : uart_tx_fifo

`default_nettype wire
